tetris_piece_rng: RTL and testbench

Parametrised successor to the 3-bit piece LFSR. It produces a stream of Tetris piece indices 0..6 from a configurable-width Galois LFSR and presents them through a valid/ready handshake to the spawn logic. It supports runtime reseeding and zero-state lock-up recovery. A compile-time option enables a 7-bag randomizer, which deals every piece exactly once per bag.

---
 rtl/tetris_piece_rng.sv | 109 ++++++++++
 tb/tb_tetris_piece_rng.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tetris_piece_rng.sv
// Tetris piece generator: a Galois LFSR feeds 0..6 piece indices to the spawn logic over a valid/ready handshake.
// Define RNG_BAG7_EN to build the 7-bag randomizer instead of plain rejection sampling.
module tetris_piece_rng #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              piece_ready,
    output logic              piece_valid,
    output logic [2:0]        piece,
    output logic [LFSR_W-1:0] lfsr_state
);

    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] seed_value;
    logic [2:0]        cand;
    logic              slot;

    // A zero register would never leave zero, so it is steered back to SEED.
    always_comb begin
        lfsr_next = (lfsr_state >> 1) ^ (lfsr_state[0] ? TAPS : '0);
        if (lfsr_state == '0) begin
            lfsr_next = SEED;
        end
    end

    assign seed_value = (seed == '0) ? SEED : seed;
    assign cand       = lfsr_state[2:0];
    assign slot       = !piece_valid || piece_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_state <= SEED;
        end else if (seed_load) begin
            lfsr_state <= seed_value;
        end else begin
            lfsr_state <= lfsr_next;
        end
    end

`ifdef RNG_BAG7_EN
    logic [6:0] bag_used;
    logic [6:0] bag_marked;
    logic [2:0] bag_pick;

    // Take the first index still free in this bag, scanning upward from the candidate and wrapping 6 -> 0.
    always_comb begin
        logic [2:0] start;
        logic [3:0] probe;
        logic       found;
        start    = (cand == 3'd7) ? 3'd0 : cand;
        bag_pick = start;
        found    = 1'b0;
        for (int k = 0; k < 7; k++) begin
            probe = {1'b0, start} + 4'(k);
            if (probe >= 4'd7) begin
                probe = probe - 4'd7;
            end
            if (!found && !bag_used[probe[2:0]]) begin
                bag_pick = probe[2:0];
                found    = 1'b1;
            end
        end
        bag_marked = bag_used | (7'd1 << bag_pick);
    end

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            bag_used <= '0;
        end else if (slot) begin
            bag_used <= (bag_marked == 7'h7F) ? 7'h00 : bag_marked;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            piece_valid <= 1'b0;
            piece       <= 3'd0;
        end else if (seed_load) begin
            piece_valid <= 1'b0;
        end else if (slot) begin
            piece_valid <= 1'b1;
            piece       <= bag_pick;
        end
    end
`else
    // Candidate 7 is rejected and leaves a single bubble; piece keeps its last value meanwhile.
    always_ff @(posedge clk) begin
        if (reset) begin
            piece_valid <= 1'b0;
            piece       <= 3'd0;
        end else if (seed_load) begin
            piece_valid <= 1'b0;
        end else if (slot) begin
            if (cand != 3'd7) begin
                piece_valid <= 1'b1;
                piece       <= cand;
            end else begin
                piece_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tetris_piece_rng.sv
// Directed bench for tetris_piece_rng; define RNG_BAG7_EN to check the 7-bag build.
module tb_tetris_piece_rng;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [2:0]  exp_piece;
        logic [15:0] exp_state;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        piece_ready = 1'b0;
    logic        piece_valid;
    logic [2:0]  piece;
    logic [15:0] lfsr_state;

    int total = 0;
    int bad = 0;
    vec_t seq [7];

    tetris_piece_rng #(.LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .piece_ready(piece_ready),
        .piece_valid(piece_valid),
        .piece      (piece),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let the edge pass and settle before sampling.
    task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] sd, input logic rdy);
        reset       = rst;
        seed_load   = ld;
        seed        = sd;
        piece_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic runSequence(input string tag);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, seq[i].ready);
            checkOutput($sformatf("%s[%0d].valid", tag, i), 32'(piece_valid), 32'(seq[i].exp_valid));
            if (seq[i].exp_valid) begin
                checkOutput($sformatf("%s[%0d].piece", tag, i), 32'(piece), 32'(seq[i].exp_piece));
            end
            checkOutput($sformatf("%s[%0d].state", tag, i), 32'(lfsr_state), 32'(seq[i].exp_state));
        end
`ifdef RNG_BAG7_EN
        checkOutput({tag, ".bag_cleared"}, 32'(dut.bag_used), 32'h0);
`endif
    endtask

    initial begin
        seq[0] = '{1'b1, 1'b1, 3'd1, 16'hE270};
        seq[1] = '{1'b1, 1'b1, 3'd0, 16'h7138};
        seq[3] = '{1'b1, 1'b1, 3'd4, 16'h1C4E};
        seq[4] = '{1'b1, 1'b1, 3'd6, 16'h0E27};
`ifdef RNG_BAG7_EN
        seq[2] = '{1'b1, 1'b1, 3'd2, 16'h389C};
        seq[5] = '{1'b1, 1'b1, 3'd3, 16'hB313};
        seq[6] = '{1'b1, 1'b1, 3'd5, 16'hED89};
`else
        seq[2] = '{1'b1, 1'b1, 3'd0, 16'h389C};
        seq[5] = '{1'b1, 1'b0, 3'd6, 16'hB313};
        seq[6] = '{1'b1, 1'b1, 3'd3, 16'hED89};
`endif

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset.valid", 32'(piece_valid), 32'h0);
        checkOutput("reset.piece", 32'(piece), 32'h0);
        checkOutput("reset.state", 32'(lfsr_state), 32'hACE1);

        $display("[TB] default sequence");
        runSequence("seq");

        $display("[TB] zero seed reload");
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        checkOutput("zseed.valid", 32'(piece_valid), 32'h0);
        checkOutput("zseed.state", 32'(lfsr_state), 32'hACE1);
        runSequence("replay");

        $display("[TB] seed load colliding with handshake");
        checkOutput("coll.pre_valid", 32'(piece_valid), 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h0001, 1'b1);
        checkOutput("coll.valid", 32'(piece_valid), 32'h0);
        checkOutput("coll.state", 32'(lfsr_state), 32'h0001);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("coll.next_valid", 32'(piece_valid), 32'h1);
        checkOutput("coll.next_piece", 32'(piece), 32'h1);
        checkOutput("coll.next_state", 32'(lfsr_state), 32'hB400);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("bp.first_valid", 32'(piece_valid), 32'h1);
        checkOutput("bp.first_piece", 32'(piece), 32'h1);
        checkOutput("bp.first_state", 32'(lfsr_state), 32'hE270);
        begin
            logic [15:0] held_states [5];
            held_states = '{16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
            for (int i = 0; i < 5; i++) begin
                applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
                checkOutput($sformatf("bp.hold[%0d].valid", i), 32'(piece_valid), 32'h1);
                checkOutput($sformatf("bp.hold[%0d].piece", i), 32'(piece), 32'h1);
                checkOutput($sformatf("bp.hold[%0d].state", i), 32'(lfsr_state), 32'(held_states[i]));
            end
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("bp.release_valid", 32'(piece_valid), 32'h1);
        checkOutput("bp.release_piece", 32'(piece), 32'h3);
        checkOutput("bp.release_state", 32'(lfsr_state), 32'hED89);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("mid.pre_valid", 32'(piece_valid), 32'h1);
        checkOutput("mid.pre_piece", 32'(piece), 32'h3);
        checkOutput("mid.pre_state", 32'(lfsr_state), 32'hC2C4);
`ifdef RNG_BAG7_EN
        checkOutput("mid.pre_bag", 32'(dut.bag_used), 32'h0A);
`endif
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("mid.valid", 32'(piece_valid), 32'h0);
        checkOutput("mid.piece", 32'(piece), 32'h0);
        checkOutput("mid.state", 32'(lfsr_state), 32'hACE1);
`ifdef RNG_BAG7_EN
        checkOutput("mid.bag", 32'(dut.bag_used), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
